timing_seq_gen: RTL and testbench

Parametrised timing-signal generator: a sequence counter driving an integrated one-hot decoder that produces timing signals T0..T(N-1) for a microprogrammed control unit. It generalises the fixed 4-to-16 decoder to a programmable sequence length, with clear, load, hold and wrap reporting. It sits between the control FSM, which drives `clr`/`inc`, and the instruction-phase logic, which consumes `tsig`.

---
 rtl/tseq_pkg.sv | 29 ++
 rtl/onehot_decoder.sv | 15 +
 rtl/timing_seq_gen.sv | 103 ++++++++++
 tb/tb_timing_seq_gen.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tseq_pkg.sv
// Shared constants and command encoding for the timing sequence generator.
package tseq_pkg;

    localparam int unsigned SEL_W_DEF = 4;
    localparam int unsigned CYC_W_DEF = 8;

    // Per-edge command after priority resolution
    typedef enum logic [1:0] {
        CMD_HOLD = 2'd0,
        CMD_INC  = 2'd1,
        CMD_LOAD = 2'd2,
        CMD_CLR  = 2'd3
    } tseq_cmd_t;

    // Priority: clear beats load beats increment beats hold
    function automatic tseq_cmd_t resolve_cmd(input logic clr, input logic load, input logic inc);
        tseq_cmd_t cmd;
        cmd = CMD_HOLD;
        if (clr) begin
            cmd = CMD_CLR;
        end else if (load) begin
            cmd = CMD_LOAD;
        end else if (inc) begin
            cmd = CMD_INC;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Combinational binary to one-hot decoder.
module onehot_decoder #(
    parameter int unsigned SEL_W = 4
) (
    input  logic [SEL_W-1:0]      sel,
    output logic [(2**SEL_W)-1:0] dec
);

    // Exactly one output bit follows the select value
    always_comb begin
        dec      = '0;
        dec[sel] = 1'b1;
    end

endmodule

// File: rtl/timing_seq_gen.sv
// Timing-signal generator: sequence counter with one-hot T0..T(N-1) decode,
// wrap pulse and saturating completed-sequence count.
// Optional feature macro: TSEQ_LOAD_EN adds the load/load_val ports.
module timing_seq_gen
    import tseq_pkg::*;
#(
    parameter int unsigned SEL_W = SEL_W_DEF,
    parameter int unsigned LAST  = (2**SEL_W) - 1,
    parameter int unsigned CYC_W = CYC_W_DEF
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  inc,
`ifdef TSEQ_LOAD_EN
    input  logic                  load,
    input  logic [SEL_W-1:0]      load_val,
`endif
    output logic [SEL_W-1:0]      sc,
    output logic [(2**SEL_W)-1:0] tsig,
    output logic                  wrap,
    output logic [CYC_W-1:0]      cyc_cnt
);

    localparam logic [SEL_W-1:0] LAST_V  = SEL_W'(LAST);
    localparam logic [CYC_W-1:0] CYC_MAX = '1;

    tseq_cmd_t        cmd_c;
    logic             load_c;
    logic [SEL_W-1:0] load_val_c;

    logic [SEL_W-1:0] sc_d, sc_q;
    logic             wrap_d, wrap_q;
    logic [CYC_W-1:0] cyc_cnt_d, cyc_cnt_q;

`ifdef TSEQ_LOAD_EN
    assign load_c     = load;
    assign load_val_c = load_val;
`else
    assign load_c     = 1'b0;
    assign load_val_c = '0;
`endif

    // Resolve the sampled control inputs into a single command
    always_comb begin
        cmd_c = resolve_cmd(clr, load_c, inc);
    end

    // Next-state for counter, wrap pulse and completed-sequence count
    always_comb begin
        sc_d      = sc_q;
        wrap_d    = 1'b0;
        cyc_cnt_d = cyc_cnt_q;
        case (cmd_c)
            CMD_CLR: begin
                sc_d = '0;
            end
            CMD_LOAD: begin
                sc_d = (load_val_c > LAST_V) ? LAST_V : load_val_c;
            end
            CMD_INC: begin
                if (sc_q == LAST_V) begin
                    sc_d   = '0;
                    wrap_d = 1'b1;
                    if (cyc_cnt_q != CYC_MAX) begin
                        cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
                    end
                end else begin
                    sc_d = sc_q + SEL_W'(1);
                end
            end
            CMD_HOLD: begin
            end
            default: begin
            end
        endcase
    end

    // State registers with asynchronous reset to T0
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sc_q      <= '0;
            wrap_q    <= 1'b0;
            cyc_cnt_q <= '0;
        end else begin
            sc_q      <= sc_d;
            wrap_q    <= wrap_d;
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

    onehot_decoder #(
        .SEL_W(SEL_W)
    ) u_dec (
        .sel(sc_q),
        .dec(tsig)
    );

    assign sc      = sc_q;
    assign wrap    = wrap_q;
    assign cyc_cnt = cyc_cnt_q;

endmodule

// File: tb/tb_timing_seq_gen.sv
// Self-checking bench for timing_seq_gen: four instances with different
// LAST/CYC_W settings checked against a behavioural sequence model.
module tb_timing_seq_gen;

    localparam int unsigned NI = 4;
    localparam int unsigned LASTS [NI] = '{15, 9, 3, 1};
    localparam int unsigned CYCWS [NI] = '{8, 8, 2, 8};

    logic clock;
    logic reset_n;
    logic clr_i [NI];
    logic inc_i [NI];
`ifdef TSEQ_LOAD_EN
    logic       load_i [NI];
    logic [3:0] lv_i   [NI];
`endif
    logic [3:0]  sc_o   [NI];
    logic [15:0] tsig_o [NI];
    logic        wrap_o [NI];
    logic [7:0]  cyc_o  [NI];

    int m_sc   [NI];
    int m_wrap [NI];
    int m_cyc  [NI];

    int n_vec;
    int n_err;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned CW = CYCWS[g];
        logic [3:0]    sc_w;
        logic [15:0]   tsig_w;
        logic          wrap_w;
        logic [CW-1:0] cyc_w;

        timing_seq_gen #(
            .SEL_W(4),
            .LAST (LASTS[g]),
            .CYC_W(CW)
        ) u_dut (
            .clock   (clock),
            .reset_n (reset_n),
            .clr     (clr_i[g]),
            .inc     (inc_i[g]),
`ifdef TSEQ_LOAD_EN
            .load    (load_i[g]),
            .load_val(lv_i[g]),
`endif
            .sc      (sc_w),
            .tsig    (tsig_w),
            .wrap    (wrap_w),
            .cyc_cnt (cyc_w)
        );

        assign sc_o[g]   = sc_w;
        assign tsig_o[g] = tsig_w;
        assign wrap_o[g] = wrap_w;
        assign cyc_o[g]  = 8'(cyc_w);
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        for (int k = 0; k < NI; k++) begin
            clr_i[k] = 1'b0;
            inc_i[k] = 1'b0;
`ifdef TSEQ_LOAD_EN
            load_i[k] = 1'b0;
            lv_i[k]   = 4'd0;
`endif
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_sc[k]   = 0;
            m_wrap[k] = 0;
            m_cyc[k]  = 0;
        end
    endtask

    // One clock: advance the reference model with the inputs seen at the edge
    task automatic cycle();
        int ld;
        int lv;
        int cmax;
        @(posedge clock);
        for (int k = 0; k < NI; k++) begin
`ifdef TSEQ_LOAD_EN
            ld = int'(load_i[k]);
            lv = int'(lv_i[k]);
`else
            ld = 0;
            lv = 0;
`endif
            cmax = (1 << CYCWS[k]) - 1;
            if (!reset_n) begin
                m_sc[k] = 0; m_wrap[k] = 0; m_cyc[k] = 0;
            end else if (clr_i[k]) begin
                m_sc[k] = 0; m_wrap[k] = 0;
            end else if (ld != 0) begin
                m_sc[k] = (lv > int'(LASTS[k])) ? int'(LASTS[k]) : lv;
                m_wrap[k] = 0;
            end else if (inc_i[k]) begin
                if (m_sc[k] == int'(LASTS[k])) begin
                    m_sc[k] = 0;
                    m_wrap[k] = 1;
                    if (m_cyc[k] < cmax) m_cyc[k] = m_cyc[k] + 1;
                end else begin
                    m_sc[k] = m_sc[k] + 1;
                    m_wrap[k] = 0;
                end
            end else begin
                m_wrap[k] = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            n_vec++;
            if (sc_o[k] !== 4'd0) begin
                n_err++; $display("FAIL reset_sc inst%0d: got %0d want 0", k, sc_o[k]);
            end
            n_vec++;
            if (tsig_o[k] !== 16'h0001) begin
                n_err++; $display("FAIL reset_tsig inst%0d: got %h want 0001", k, tsig_o[k]);
            end
            n_vec++;
            if (wrap_o[k] !== 1'b0 || cyc_o[k] !== 8'd0) begin
                n_err++; $display("FAIL reset_wrap_cyc inst%0d: got %b/%0d want 0/0", k, wrap_o[k], cyc_o[k]);
            end
            inc_i[k] = 1'b1;
        end
        cycle();
        cycle();
        for (int k = 0; k < NI; k++) begin
            n_vec++;
            if (sc_o[k] !== 4'd0) begin
                n_err++; $display("FAIL reset_hold_sc inst%0d: got %0d want 0", k, sc_o[k]);
            end
        end
        idle();
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_walk();
        logic [15:0] exp_t;
        idle();
        inc_i[0] = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            cycle();
            exp_t = 16'(1) << (c % 16);
            n_vec++;
            if (sc_o[0] !== 4'(c % 16) || tsig_o[0] !== exp_t) begin
                n_err++; $display("FAIL walk_sc c%0d: got %0d/%h want %0d/%h", c, sc_o[0], tsig_o[0], c % 16, exp_t);
            end
            n_vec++;
            if (wrap_o[0] !== (c == 16)) begin
                n_err++; $display("FAIL walk_wrap c%0d: got %b want %b", c, wrap_o[0], c == 16);
            end
        end
        n_vec++;
        if (cyc_o[0] !== 8'd1) begin
            n_err++; $display("FAIL walk_cyc: got %0d want 1", cyc_o[0]);
        end
        inc_i[0] = 1'b0;
        cycle();
        n_vec++;
        if (wrap_o[0] !== 1'b0 || sc_o[0] !== 4'd0) begin
            n_err++; $display("FAIL walk_after: got wrap %b sc %0d want 0 0", wrap_o[0], sc_o[0]);
        end
    endtask

    task automatic test_last9();
        idle();
        clr_i[1] = 1'b1;
        cycle();
        clr_i[1] = 1'b0;
        inc_i[1] = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            cycle();
            n_vec++;
            if (sc_o[1] !== 4'(c % 10) || tsig_o[1][15:10] !== 6'd0) begin
                n_err++; $display("FAIL last9_sc c%0d: got %0d/%h want %0d", c, sc_o[1], tsig_o[1], c % 10);
            end
            n_vec++;
            if (wrap_o[1] !== (c % 10 == 0)) begin
                n_err++; $display("FAIL last9_wrap c%0d: got %b want %b", c, wrap_o[1], c % 10 == 0);
            end
        end
        idle();
    endtask

    task automatic test_clr_inc();
        idle();
        clr_i[0] = 1'b1;
        cycle();
        clr_i[0] = 1'b0;
        inc_i[0] = 1'b1;
        repeat (6) cycle();
        n_vec++;
        if (sc_o[0] !== 4'd6) begin
            n_err++; $display("FAIL clrinc_pre: got %0d want 6", sc_o[0]);
        end
        clr_i[0] = 1'b1;
        cycle();
        n_vec++;
        if (sc_o[0] !== 4'd0 || tsig_o[0] !== 16'h0001 || wrap_o[0] !== 1'b0) begin
            n_err++; $display("FAIL clrinc_mid: got %0d/%h/%b want 0/0001/0", sc_o[0], tsig_o[0], wrap_o[0]);
        end
        idle();
        clr_i[1] = 1'b1;
        cycle();
        clr_i[1] = 1'b0;
        inc_i[1] = 1'b1;
        repeat (9) cycle();
        clr_i[1] = 1'b1;
        cycle();
        n_vec++;
        if (sc_o[1] !== 4'd0 || wrap_o[1] !== 1'b0 || cyc_o[1] !== 8'(m_cyc[1])) begin
            n_err++; $display("FAIL clrinc_last: got %0d/%b/%0d want 0/0/%0d", sc_o[1], wrap_o[1], cyc_o[1], m_cyc[1]);
        end
        idle();
    endtask

`ifdef TSEQ_LOAD_EN
    task automatic test_load();
        idle();
        load_i[1] = 1'b1;
        lv_i[1]   = 4'd12;
        cycle();
        n_vec++;
        if (sc_o[1] !== 4'd9 || tsig_o[1] !== 16'h0200) begin
            n_err++; $display("FAIL load_clamp: got %0d/%h want 9/0200", sc_o[1], tsig_o[1]);
        end
        lv_i[1] = 4'd4;
        cycle();
        n_vec++;
        if (sc_o[1] !== 4'd4) begin
            n_err++; $display("FAIL load_val: got %0d want 4", sc_o[1]);
        end
        lv_i[1]  = 4'd7;
        clr_i[1] = 1'b1;
        cycle();
        n_vec++;
        if (sc_o[1] !== 4'd0) begin
            n_err++; $display("FAIL load_clr: got %0d want 0", sc_o[1]);
        end
        clr_i[1] = 1'b0;
        inc_i[1] = 1'b1;
        lv_i[1]  = 4'd2;
        cycle();
        n_vec++;
        if (sc_o[1] !== 4'd2 || wrap_o[1] !== 1'b0) begin
            n_err++; $display("FAIL load_inc: got %0d/%b want 2/0", sc_o[1], wrap_o[1]);
        end
        idle();
    endtask
`endif

    task automatic test_async_reset();
        idle();
        clr_i[0] = 1'b1;
        cycle();
        clr_i[0] = 1'b0;
        inc_i[0] = 1'b1;
        repeat (5) cycle();
        inc_i[0] = 1'b0;
        n_vec++;
        if (sc_o[0] !== 4'd5) begin
            n_err++; $display("FAIL areset_pre: got %0d want 5", sc_o[0]);
        end
        #3;
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            n_vec++;
            if (sc_o[k] !== 4'd0 || tsig_o[k] !== 16'h0001 || wrap_o[k] !== 1'b0 || cyc_o[k] !== 8'd0) begin
                n_err++; $display("FAIL areset inst%0d: got %0d/%h/%b/%0d want 0/0001/0/0", k, sc_o[k], tsig_o[k], wrap_o[k], cyc_o[k]);
            end
        end
        #2;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_saturate();
        int exp_c;
        idle();
        inc_i[2] = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            cycle();
            exp_c = (c / 4 > 3) ? 3 : c / 4;
            n_vec++;
            if (cyc_o[2] !== 8'(exp_c)) begin
                n_err++; $display("FAIL sat_cyc c%0d: got %0d want %0d", c, cyc_o[2], exp_c);
            end
        end
        idle();
    endtask

    task automatic test_back_to_back();
        idle();
        clr_i[3] = 1'b1;
        cycle();
        clr_i[3] = 1'b0;
        inc_i[3] = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            cycle();
            n_vec++;
            if (wrap_o[3] !== (c % 2 == 0) || sc_o[3] !== 4'(c % 2)) begin
                n_err++; $display("FAIL b2b c%0d: got wrap %b sc %0d want %b %0d", c, wrap_o[3], sc_o[3], c % 2 == 0, c % 2);
            end
        end
        idle();
    endtask

    task automatic test_random();
        logic [15:0] exp_t;
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < NI; k++) begin
                clr_i[k] = ($urandom_range(0, 15) == 0);
                inc_i[k] = ($urandom_range(0, 3) != 0);
`ifdef TSEQ_LOAD_EN
                load_i[k] = ($urandom_range(0, 7) == 0);
                lv_i[k]   = 4'($urandom_range(0, 15));
`endif
            end
            cycle();
            for (int k = 0; k < NI; k++) begin
                exp_t = 16'(1) << m_sc[k];
                n_vec++;
                if (sc_o[k] !== 4'(m_sc[k]) || tsig_o[k] !== exp_t) begin
                    n_err++; $display("FAIL rand_sc c%0d inst%0d: got %0d/%h want %0d/%h", c, k, sc_o[k], tsig_o[k], m_sc[k], exp_t);
                end
                n_vec++;
                if (wrap_o[k] !== 1'(m_wrap[k]) || cyc_o[k] !== 8'(m_cyc[k])) begin
                    n_err++; $display("FAIL rand_wrap_cyc c%0d inst%0d: got %b/%0d want %0d/%0d", c, k, wrap_o[k], cyc_o[k], m_wrap[k], m_cyc[k]);
                end
            end
        end
        idle();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        test_reset();
        test_walk();
        test_last9();
        test_clr_inc();
`ifdef TSEQ_LOAD_EN
        test_load();
`endif
        test_async_reset();
        test_saturate();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
